csa_resolver: RTL and testbench

//  Final carry-propagate stage for the Wallace pipeline: accepts one redundant (sum u, carry v) pair

---
 rtl/csa_resolver_pkg.sv | 19 +
 rtl/csa_resolver_slice_adder.sv | 35 +++
 rtl/csa_resolver.sv | 116 +++++++++++
 tb/tb_csa_resolver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_resolver_pkg.sv
// Shared definitions for the carry-save resolver: FSM state encodings and sizing helpers.
package csa_resolver_pkg;

  typedef enum logic [1:0] {
    CSA_ST_IDLE = 2'd0,
    CSA_ST_ADD  = 2'd1,
    CSA_ST_DONE = 2'd2
  } csa_state_t;

  // Result width: the wider weighted operand plus one bit for the final carry.
  function automatic int csa_w_out(input int w_u, input int w_v, input int v_shift);
    return ((w_u > w_v + v_shift) ? w_u : w_v + v_shift) + 1;
  endfunction

  function automatic int csa_nslice(input int w_out, input int slice);
    return (w_out + slice - 1) / slice;
  endfunction

endpackage

// File: rtl/csa_resolver_slice_adder.sv
// SLICE-bit ripple-carry adder built from full-adder cells; the resolver reuses one
// instance every ADD cycle.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module csa_slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);
  logic [SLICE:0] c;

  assign c[0] = cin;
  assign cout = c[SLICE];

  full_adder u_fa [SLICE-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[SLICE-1:0]),
    .s  (s),
    .co (c[SLICE:1])
  );
endmodule

// File: rtl/csa_resolver.sv
// Iterative carry-propagate resolver: out_sum = u + (v << V_SHIFT), SLICE bits per cycle.
// Define CSA_RESOLVE_CHK_EN to add the chk_err self-check output.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int W_U     = 10,
  parameter int W_V     = 8,
  parameter int V_SHIFT = 2,
  parameter int SLICE   = 4,
  localparam int W_OUT  = csa_w_out(W_U, W_V, V_SHIFT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_U-1:0]   u,
  input  logic [W_V-1:0]   v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_sum
`ifdef CSA_RESOLVE_CHK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int NSLICE = csa_nslice(W_OUT, SLICE);
  localparam int PW     = NSLICE * SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  csa_state_t                     state;
  logic [IW-1:0]                  idx;
  logic                           carry;
  logic [NSLICE-1:0][SLICE-1:0]   u_q, v_q, sum_q;
  logic [SLICE-1:0]               s_slice;
  logic                           c_out;
  logic [PW-1:0]                  sum_flat;

  assign in_ready  = (state == CSA_ST_IDLE) && !reset;
  assign sum_flat  = sum_q;
  assign out_sum   = sum_flat[W_OUT-1:0];

  // Padding bits above W_OUT never carry data; the sizing guarantees they stay zero.
  generate
    if (PW > W_OUT) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^sum_flat[PW-1:W_OUT];
    end
  endgenerate

  csa_slice_adder #(.SLICE(SLICE)) u_slice (
    .a    (u_q[idx]),
    .b    (v_q[idx]),
    .cin  (carry),
    .s    (s_slice),
    .cout (c_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CSA_ST_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum_q     <= '0;
      u_q       <= '0;
      v_q       <= '0;
    end else begin
      case (state)
        CSA_ST_IDLE: begin
          if (in_valid) begin
            u_q   <= PW'(u);
            v_q   <= PW'(v) << V_SHIFT;
            carry <= 1'b0;
            idx   <= '0;
            sum_q <= '0;
            state <= CSA_ST_ADD;
          end
        end
        CSA_ST_ADD: begin
          sum_q[idx] <= s_slice;
          carry      <= c_out;
          if (idx == LAST) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= CSA_ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        CSA_ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= CSA_ST_IDLE;
          end
        end
        default: state <= CSA_ST_IDLE;
      endcase
    end
  end

`ifdef CSA_RESOLVE_CHK_EN
  logic [W_OUT-1:0] chk_ref_q;

  always_ff @(posedge clk) begin
    if (reset) chk_ref_q <= '0;
    else if (in_valid && in_ready)
      chk_ref_q <= W_OUT'(u) + (W_OUT'(v) << V_SHIFT);
  end

  // Only meaningful once all slices are written; IDLE/ADD report clean.
  assign chk_err = (state == CSA_ST_DONE) && (out_sum != chk_ref_q);
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed scenarios plus randomized back-to-back
// traffic checked against an arithmetic reference.
module tb_csa_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  u;
  logic [7:0]  v;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_sum;
`ifdef CSA_RESOLVE_CHK_EN
  logic        chk_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  csa_resolver dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .v         (v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
`ifdef CSA_RESOLVE_CHK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] model(input logic [9:0] uu, input logic [7:0] vv);
    int r;
    r = int'(uu) + int'(vv) * 4;
    return r[10:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and return just after the accepting edge; ok=0 if never accepted.
  task automatic send(input logic [9:0] uu, input logic [7:0] vv, output bit ok);
    int n;
    u = uu; v = vv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
    u = $urandom; v = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; u = '0; v = '0;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== 11'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: valid=%b sum=%0d ready=%b, want 0/0/0", out_valid, out_sum, in_ready);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [9:0] tu [3];
    logic [7:0] tv [3];
    bit ok;
    int lat;
    bit ready_bad;
    tu[0] = 10'd5;    tv[0] = 8'd3;
    tu[1] = 10'h3FF;  tv[1] = 8'hFF;
    tu[2] = 10'd0;    tv[2] = 8'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(tu[i], tv[i], ok);
      ready_bad = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        if (in_ready !== 1'b0) ready_bad = 1'b1;
        tick(); lat++;
      end
      vectors++;
      if (!ok || lat != 3) begin
        miscompares++;
        $display("FAIL latency_%0d: accepted=%b edges=%0d, want 1/3", i, ok, lat);
      end
      vectors++;
      if (out_sum !== model(tu[i], tv[i])) begin
        miscompares++;
        $display("FAIL sum_%0d: got %h want %h", i, out_sum, model(tu[i], tv[i]));
      end
`ifdef CSA_RESOLVE_CHK_EN
      vectors++;
      if (chk_err !== 1'b0) begin
        miscompares++;
        $display("FAIL chk_err_%0d: got %b want 0", i, chk_err);
      end
`endif
      if (in_ready !== 1'b0) ready_bad = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (ready_bad || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL handoff_%0d: ready_low_err=%b ready=%b valid=%b, want 0/1/0",
                 i, ready_bad, in_ready, out_valid);
      end
    end
    vectors++;
    if (out_sum !== 11'd0) begin
      miscompares++;
      $display("FAIL zero_sum: got %h want 000", out_sum);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    out_ready = 1'b0;
    send(10'd100, 8'd25, ok);
    wait_valid(lat);
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL bp_latency: edges=%0d want 3", lat);
    end
    in_valid = 1'b1; u = 10'd7; v = 8'd9;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== 11'd200 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: valid=%b sum=%0d ready=%b, want 1/200/0",
                 c, out_valid, out_sum, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 11'd200) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b ready=%b sum=%0d, want 0/1/200", out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_reset_mid_add();
    bit ok;
    int lat;
    out_ready = 1'b1;
    send(10'd100, 8'd25, ok);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== 11'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b sum=%0d ready=%b, want 0/0/1", out_valid, out_sum, in_ready);
    end
    tick(); tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_pulse: valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
    send(10'd1, 8'd1, ok);
    wait_valid(lat);
    vectors++;
    if (lat != 3 || out_sum !== 11'd5) begin
      miscompares++;
      $display("FAIL post_reset_op: edges=%0d sum=%0d, want 3/5", lat, out_sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    logic [9:0]  ru;
    logic [7:0]  rv;
    logic [10:0] exp;
    bit done;
    int held;
    for (int n = 0; n < 1000; n++) begin
      ru = $urandom;
      rv = $urandom;
      if (n == 0) begin ru = 10'h3FF; rv = 8'hFF; end
      exp = model(ru, rv);
      out_ready = 1'b0;
      send(ru, rv, ok);
      wait_valid(lat);
      vectors++;
      if (!ok || lat != 3 || out_sum !== exp) begin
        miscompares++;
        $display("FAIL b2b_%0d: u=%h v=%h accepted=%b edges=%0d sum=%h, want 1/3/%h",
                 n, ru, rv, ok, lat, out_sum, exp);
      end
`ifdef CSA_RESOLVE_CHK_EN
      vectors++;
      if (chk_err !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_chk_%0d: chk_err=%b want 0", n, chk_err);
      end
`endif
      done = 1'b0;
      held = 0;
      while (!done && held < 20) begin
        out_ready = $urandom_range(0, 1);
        done = out_ready;
        tick();
        held++;
        if (!done) begin
          vectors++;
          if (out_valid !== 1'b1 || out_sum !== exp) begin
            miscompares++;
            $display("FAIL b2b_hold_%0d: valid=%b sum=%h want 1/%h", n, out_valid, out_sum, exp);
          end
        end
      end
      if (!done) begin
        out_ready = 1'b1;
        tick();
      end
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_handoff_%0d: valid=%b ready=%b want 0/1", n, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_add();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
